// File: rtl/move_scheduler.sv
// Tile-based movement scheduler: every FRAMES_PER_STEP frames it checks the
// pending turn and then the current heading against the maze, then advances one tile.
module move_scheduler #(
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned GRID_W          = 28,
  parameter int unsigned GRID_H          = 31,
  parameter int unsigned START_X         = 13,
  parameter int unsigned START_Y         = 23,
  localparam int unsigned COORD_W        = 5,
  localparam int unsigned DIR_W          = 2,
  localparam int unsigned CNT_W          = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic [3:0]         btn,
  output logic               wall_req,
  output logic [COORD_W-1:0] wall_x,
  output logic [COORD_W-1:0] wall_y,
  input  logic               wall_ack,
  input  logic               wall_hit,
  output logic [COORD_W-1:0] pac_x,
  output logic [COORD_W-1:0] pac_y,
  output logic [DIR_W-1:0]   pac_dir,
  output logic               moving,
  output logic               step_done
);

  localparam logic [DIR_W-1:0] DIR_LEFT  = DIR_W'(0);
  localparam logic [DIR_W-1:0] DIR_UP    = DIR_W'(1);
  localparam logic [DIR_W-1:0] DIR_RIGHT = DIR_W'(2);
  localparam logic [DIR_W-1:0] DIR_DOWN  = DIR_W'(3);

  typedef enum logic [2:0] {
    IDLE, CHK_PEND, WAIT_PEND, CHK_CUR, WAIT_CUR, MOVE
  } state_t;

  state_t               state_q, state_d;
  logic                 vsync_q, vsync_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIR_W-1:0]     pend_dir_q, pend_dir_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [DIR_W-1:0]     qdir_q, qdir_d;
  logic [COORD_W-1:0]   pac_x_q, pac_x_d, pac_y_q, pac_y_d;
  logic [DIR_W-1:0]     pac_dir_q, pac_dir_d;
  logic                 moving_q, moving_d, step_done_q, step_done_d;
  logic                 wall_req_q, wall_req_d;
  logic [COORD_W-1:0]   wall_x_q, wall_x_d, wall_y_q, wall_y_d;
  logic                 frame_evt;

  // Neighbour column/row with wrap-around on both axes
  function automatic logic [COORD_W-1:0] next_x(input logic [COORD_W-1:0] x,
                                                input logic [DIR_W-1:0] dir);
    next_x = x;
    if (dir == DIR_LEFT)
      next_x = (x == '0) ? COORD_W'(GRID_W - 1) : x - COORD_W'(1);
    else if (dir == DIR_RIGHT)
      next_x = (x == COORD_W'(GRID_W - 1)) ? '0 : x + COORD_W'(1);
  endfunction

  function automatic logic [COORD_W-1:0] next_y(input logic [COORD_W-1:0] y,
                                                input logic [DIR_W-1:0] dir);
    next_y = y;
    if (dir == DIR_UP)
      next_y = (y == '0) ? COORD_W'(GRID_H - 1) : y - COORD_W'(1);
    else if (dir == DIR_DOWN)
      next_y = (y == COORD_W'(GRID_H - 1)) ? '0 : y + COORD_W'(1);
  endfunction

  assign frame_evt = vsync_q & ~vsync;

  always_comb begin
    state_d      = state_q;
    vsync_d      = vsync;
    cnt_d        = cnt_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    qdir_d       = qdir_q;
    pac_x_d      = pac_x_q;
    pac_y_d      = pac_y_q;
    pac_dir_d    = pac_dir_q;
    moving_d     = moving_q;
    step_done_d  = 1'b0;
    wall_req_d   = wall_req_q;
    wall_x_d     = wall_x_q;
    wall_y_d     = wall_y_q;

    case (state_q)
      IDLE: begin
        if (frame_evt) begin
          if (cnt_q == CNT_W'(FRAMES_PER_STEP - 1)) begin
            cnt_d   = '0;
            state_d = CHK_PEND;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CHK_PEND: begin
        if (pend_valid_q && (pend_dir_q != pac_dir_q)) begin
          qdir_d     = pend_dir_q;
          wall_req_d = 1'b1;
          wall_x_d   = next_x(pac_x_q, pend_dir_q);
          wall_y_d   = next_y(pac_y_q, pend_dir_q);
          state_d    = WAIT_PEND;
        end else begin
          state_d = CHK_CUR;
        end
      end
      WAIT_PEND: begin
        if (wall_ack) begin
          wall_req_d = 1'b0;
          if (!wall_hit) begin
            pac_dir_d    = qdir_q;
            pend_valid_d = 1'b0;
            state_d      = MOVE;
          end else begin
            state_d = CHK_CUR;
          end
        end
      end
      CHK_CUR: begin
        wall_req_d = 1'b1;
        wall_x_d   = next_x(pac_x_q, pac_dir_q);
        wall_y_d   = next_y(pac_y_q, pac_dir_q);
        state_d    = WAIT_CUR;
      end
      WAIT_CUR: begin
        if (wall_ack) begin
          wall_req_d = 1'b0;
          if (wall_hit) begin
            moving_d    = 1'b0;
            step_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = MOVE;
          end
        end
      end
      MOVE: begin
        pac_x_d     = next_x(pac_x_q, pac_dir_q);
        pac_y_d     = next_y(pac_y_q, pac_dir_q);
        moving_d    = 1'b1;
        step_done_d = 1'b1;
        if (pend_dir_q == pac_dir_q) pend_valid_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A fresh press wins over any clear in the same cycle; lowest index has priority
    if (|btn) begin
      pend_valid_d = 1'b1;
      if (btn[0])      pend_dir_d = DIR_LEFT;
      else if (btn[1]) pend_dir_d = DIR_UP;
      else if (btn[2]) pend_dir_d = DIR_RIGHT;
      else             pend_dir_d = DIR_DOWN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b1;
      cnt_q        <= '0;
      pend_dir_q   <= DIR_LEFT;
      pend_valid_q <= 1'b0;
      qdir_q       <= DIR_LEFT;
      pac_x_q      <= COORD_W'(START_X);
      pac_y_q      <= COORD_W'(START_Y);
      pac_dir_q    <= DIR_LEFT;
      moving_q     <= 1'b0;
      step_done_q  <= 1'b0;
      wall_req_q   <= 1'b0;
      wall_x_q     <= '0;
      wall_y_q     <= '0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      cnt_q        <= cnt_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      qdir_q       <= qdir_d;
      pac_x_q      <= pac_x_d;
      pac_y_q      <= pac_y_d;
      pac_dir_q    <= pac_dir_d;
      moving_q     <= moving_d;
      step_done_q  <= step_done_d;
      wall_req_q   <= wall_req_d;
      wall_x_q     <= wall_x_d;
      wall_y_q     <= wall_y_d;
    end
  end

  assign pac_x     = pac_x_q;
  assign pac_y     = pac_y_q;
  assign pac_dir   = pac_dir_q;
  assign moving    = moving_q;
  assign step_done = step_done_q;
  assign wall_req  = wall_req_q;
  assign wall_x    = wall_x_q;
  assign wall_y    = wall_y_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Scenario bench for move_scheduler: expected maze queries are queued per
// scenario and popped as the DUT issues each wall request.
module tb_move_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       vsync = 1'b1;
  logic [3:0] btn = 4'd0;
  logic       wall_ack = 1'b0;
  logic       wall_hit = 1'b0;
  logic       wall_req;
  logic [4:0] wall_x, wall_y, pac_x, pac_y;
  logic [1:0] pac_dir;
  logic       moving, step_done;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } q_t;

  q_t exp_q[$];
  int total = 0;
  int bad   = 0;

  move_scheduler dut (
    .clk(clk), .reset(reset), .vsync(vsync), .btn(btn),
    .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
    .wall_ack(wall_ack), .wall_hit(wall_hit),
    .pac_x(pac_x), .pac_y(pac_y), .pac_dir(pac_dir),
    .moving(moving), .step_done(step_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic q_t mk(input int x, input int y);
    q_t r;
    r.x = 5'(x);
    r.y = 5'(y);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; btn = 4'd0; vsync = 1'b1; wall_ack = 1'b0; wall_hit = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk) vsync = 1'b0;
      @(negedge clk) vsync = 1'b1;
    end
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk) btn = b;
    @(negedge clk) btn = 4'd0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wall_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic respond(input logic hit, input int dly);
    repeat (dly - 1) @(negedge clk);
    wall_ack = 1'b1; wall_hit = hit;
    @(negedge clk);
    wall_ack = 1'b0; wall_hit = 1'b0;
  endtask

  task automatic serve(input logic hit, input int dly, output bit ok,
                       output logic [4:0] x, output logic [4:0] y);
    wait_req(ok);
    x = wall_x;
    y = wall_y;
    if (ok) respond(hit, dly);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (step_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({pac_x, pac_y, pac_dir} !== {5'd13, 5'd23, 2'd0}) begin
      bad++; $display("FAIL reset_pos: got (%0d,%0d,%0d) want (13,23,0)", pac_x, pac_y, pac_dir);
    end
    total++;
    if ({moving, step_done, wall_req, wall_x, wall_y} !== 13'd0) begin
      bad++; $display("FAIL reset_flags: got mv=%b sd=%b rq=%b wx=%0d wy=%0d want all 0",
                      moving, step_done, wall_req, wall_x, wall_y);
    end
    // ack in the first cycle after release must be ignored
    reset = 1'b1; wall_ack = 1'b1; wall_hit = 1'b0;
    @(negedge clk);
    wall_ack = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({wall_req, step_done, pac_x} !== {1'b0, 1'b0, 5'd13}) begin
      bad++; $display("FAIL reset_stray_ack: got rq=%b sd=%b x=%0d want 0 0 13", wall_req, step_done, pac_x);
    end
  endtask

  task automatic test_basic_step();
    bit ok, dn;
    logic [4:0] x, y;
    q_t e;
    exp_q.push_back(mk(12, 23));
    frames(3);
    repeat (4) @(negedge clk);
    total++;
    if (wall_req !== 1'b0) begin
      bad++; $display("FAIL s1_early_req: got %b want 0 after 3 frames", wall_req);
    end
    frames(1);
    serve(1'b0, 1, ok, x, y);
    e = exp_q.pop_front();
    total++;
    if (!ok || x !== e.x || y !== e.y) begin
      bad++; $display("FAIL s1_query: got ok=%0d (%0d,%0d) want (%0d,%0d)", ok, x, y, e.x, e.y);
    end
    total++;
    if (wall_req !== 1'b0) begin
      bad++; $display("FAIL s1_req_drop: got %b want 0 after ack", wall_req);
    end
    wait_done(dn);
    total++;
    if (!dn || pac_x !== 5'd12 || pac_y !== 5'd23 || moving !== 1'b1) begin
      bad++; $display("FAIL s1_result: got done=%0d (%0d,%0d) mv=%b want 1 (12,23) 1", dn, pac_x, pac_y, moving);
    end
    @(negedge clk);
    total++;
    if (step_done !== 1'b0) begin
      bad++; $display("FAIL s1_pulse: got step_done=%b want 0 one cycle later", step_done);
    end
  endtask

  task automatic test_turn();
    bit ok, dn;
    logic [4:0] x, y;
    q_t e;
    do_reset();
    @(negedge clk) btn = 4'b0010;
    exp_q.push_back(mk(13, 22));
    exp_q.push_back(mk(13, 21));
    for (int s = 0; s < 2; s++) begin
      frames(4);
      serve(1'b0, 1, ok, x, y);
      e = exp_q.pop_front();
      total++;
      if (!ok || x !== e.x || y !== e.y) begin
        bad++; $display("FAIL s2_query%0d: got ok=%0d (%0d,%0d) want (%0d,%0d)", s, ok, x, y, e.x, e.y);
      end
      wait_done(dn);
      total++;
      if (!dn || pac_dir !== 2'd1 || pac_x !== 5'd13 || pac_y !== 5'(22 - s)) begin
        bad++; $display("FAIL s2_result%0d: got done=%0d dir=%0d (%0d,%0d) want 1 dir=1 (13,%0d)",
                        s, dn, pac_dir, pac_x, pac_y, 22 - s);
      end
    end
    btn = 4'd0;
  endtask

  task automatic test_pend_blocked();
    bit ok, dn;
    logic [4:0] x, y;
    q_t e;
    do_reset();
    press(4'b0010);
    exp_q.push_back(mk(13, 22));
    exp_q.push_back(mk(12, 23));
    exp_q.push_back(mk(12, 22));
    frames(4);
    for (int s = 0; s < 2; s++) begin
      serve(s == 0, 1, ok, x, y);
      e = exp_q.pop_front();
      total++;
      if (!ok || x !== e.x || y !== e.y) begin
        bad++; $display("FAIL s3_query%0d: got ok=%0d (%0d,%0d) want (%0d,%0d)", s, ok, x, y, e.x, e.y);
      end
    end
    wait_done(dn);
    total++;
    if (!dn || pac_dir !== 2'd0 || pac_x !== 5'd12 || pac_y !== 5'd23) begin
      bad++; $display("FAIL s3_result: got done=%0d dir=%0d (%0d,%0d) want 1 dir=0 (12,23)", dn, pac_dir, pac_x, pac_y);
    end
    // pending up survives, so the next step tries it again
    frames(4);
    serve(1'b0, 1, ok, x, y);
    e = exp_q.pop_front();
    total++;
    if (!ok || x !== e.x || y !== e.y) begin
      bad++; $display("FAIL s3_retry: got ok=%0d (%0d,%0d) want (%0d,%0d)", ok, x, y, e.x, e.y);
    end
    wait_done(dn);
    total++;
    if (!dn || pac_dir !== 2'd1 || pac_y !== 5'd22) begin
      bad++; $display("FAIL s3_retry_result: got done=%0d dir=%0d y=%0d want 1 dir=1 y=22", dn, pac_dir, pac_y);
    end
  endtask

  task automatic test_wrap();
    bit ok, dn;
    logic [4:0] x, y;
    q_t e;
    do_reset();
    for (int s = 0; s < 14; s++) exp_q.push_back(mk((s < 13) ? 12 - s : 27, 23));
    exp_q.push_back(mk(0, 23));
    for (int s = 0; s < 15; s++) begin
      if (s == 14) press(4'b0100);
      frames(4);
      serve(1'b0, 1, ok, x, y);
      e = exp_q.pop_front();
      total++;
      if (!ok || x !== e.x || y !== e.y) begin
        bad++; $display("FAIL s4_query%0d: got ok=%0d (%0d,%0d) want (%0d,%0d)", s, ok, x, y, e.x, e.y);
      end
      wait_done(dn);
      if (s == 13) begin
        total++;
        if (!dn || pac_x !== 5'd27) begin
          bad++; $display("FAIL s4_wrap_left: got done=%0d x=%0d want 1 27", dn, pac_x);
        end
      end
    end
    total++;
    if (!dn || pac_x !== 5'd0 || pac_dir !== 2'd2) begin
      bad++; $display("FAIL s4_wrap_right: got done=%0d x=%0d dir=%0d want 1 0 2", dn, pac_x, pac_dir);
    end
  endtask

  task automatic test_both_hit();
    bit ok, dn;
    logic [4:0] x, y;
    q_t e;
    do_reset();
    exp_q.push_back(mk(12, 23));
    exp_q.push_back(mk(12, 22));
    exp_q.push_back(mk(11, 23));
    frames(4);
    serve(1'b0, 1, ok, x, y);
    e = exp_q.pop_front();
    wait_done(dn);
    total++;
    if (!ok || x !== e.x || y !== e.y || moving !== 1'b1) begin
      bad++; $display("FAIL s5_setup: got ok=%0d (%0d,%0d) mv=%b want (%0d,%0d) 1", ok, x, y, moving, e.x, e.y);
    end
    press(4'b0010);
    frames(4);
    for (int s = 0; s < 2; s++) begin
      serve(1'b1, 2, ok, x, y);
      e = exp_q.pop_front();
      total++;
      if (!ok || x !== e.x || y !== e.y) begin
        bad++; $display("FAIL s5_query%0d: got ok=%0d (%0d,%0d) want (%0d,%0d)", s, ok, x, y, e.x, e.y);
      end
    end
    wait_done(dn);
    total++;
    if (!dn || moving !== 1'b0 || {pac_x, pac_y, pac_dir} !== {5'd12, 5'd23, 2'd0}) begin
      bad++; $display("FAIL s5_result: got done=%0d mv=%b (%0d,%0d,%0d) want 1 0 (12,23,0)",
                      dn, moving, pac_x, pac_y, pac_dir);
    end
  endtask

  task automatic test_slow_ack_reset();
    bit ok, dn, stable, quiet;
    logic [4:0] x, y;
    q_t e;
    do_reset();
    exp_q.push_back(mk(12, 23));
    exp_q.push_back(mk(11, 23));
    exp_q.push_back(mk(12, 23));
    frames(4);
    wait_req(ok);
    x = wall_x; y = wall_y;
    e = exp_q.pop_front();
    total++;
    if (!ok || x !== e.x || y !== e.y) begin
      bad++; $display("FAIL s6_query: got ok=%0d (%0d,%0d) want (%0d,%0d)", ok, x, y, e.x, e.y);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) vsync = (i % 2 == 1);
      if (wall_x !== x || wall_y !== y || wall_req !== 1'b1) stable = 1'b0;
    end
    vsync = 1'b1;
    total++;
    if (!stable) begin
      bad++; $display("FAIL s6_stable: got (%0d,%0d) rq=%b want (%0d,%0d) held with rq=1", wall_x, wall_y, wall_req, x, y);
    end
    respond(1'b0, 1);
    wait_done(dn);
    total++;
    if (!dn || pac_x !== 5'd12) begin
      bad++; $display("FAIL s6_slow_result: got done=%0d x=%0d want 1 12", dn, pac_x);
    end
    frames(3);
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (wall_req !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++; $display("FAIL s6_dropped: got a request after 3 frames want none");
    end
    frames(1);
    wait_req(ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || wall_x !== e.x || wall_y !== e.y) begin
      bad++; $display("FAIL s6_query2: got ok=%0d (%0d,%0d) want (%0d,%0d)", ok, wall_x, wall_y, e.x, e.y);
    end
    press(4'b0010);
    @(negedge clk) reset = 1'b0;
    #1;
    total++;
    if ({pac_x, pac_y, pac_dir, moving, step_done, wall_req, wall_x, wall_y} !==
        {5'd13, 5'd23, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0}) begin
      bad++; $display("FAIL s6_async_reset: got (%0d,%0d,%0d) mv=%b sd=%b rq=%b w=(%0d,%0d) want (13,23,0) 0 0 0 (0,0)",
                      pac_x, pac_y, pac_dir, moving, step_done, wall_req, wall_x, wall_y);
    end
    @(negedge clk) reset = 1'b1;
    frames(4);
    serve(1'b0, 1, ok, x, y);
    e = exp_q.pop_front();
    total++;
    if (!ok || x !== e.x || y !== e.y) begin
      bad++; $display("FAIL s6_post_reset: got ok=%0d (%0d,%0d) want (%0d,%0d)", ok, x, y, e.x, e.y);
    end
    wait_done(dn);
  endtask

  initial begin
    test_reset();
    test_basic_step();
    test_turn();
    test_pend_blocked();
    test_wrap();
    test_both_hit();
    test_slow_ack_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
